// File: rtl/vm2002_inventory_arb_if.sv
// Purpose : bundle of supplier-load, user-purchase and output-stage signals
//           shared by the VM2002 inventory arbiter and whatever drives it.
// Modports: slave  = arbiter side (takes requests, drives results)
//           master = requester / output-stage side
interface vm2002_inventory_arb_if #(
   parameter int IDX_W  = 2,
   parameter int CNT_W  = 4,
   parameter int COST_W = 8
);
   // supplier restock port
   logic              sup_valid;
   logic [IDX_W-1:0]  sup_item;
   logic [CNT_W-1:0]  sup_count;
   logic [COST_W-1:0] sup_cost;
   logic              sup_ready;
   // user purchase port
   logic              usr_req;
   logic [IDX_W-1:0]  usr_item;
   logic [15:0]       usr_amount;
   logic              usr_ack;
   logic [1:0]        usr_status;
   logic [15:0]       usr_change;
   // output stage
   logic              dispense;
   logic [IDX_W-1:0]  dispense_item;
   logic              busy;

   modport slave (
      input  sup_valid, sup_item, sup_count, sup_cost,
      output sup_ready,
      input  usr_req, usr_item, usr_amount,
      output usr_ack, usr_status, usr_change,
      output dispense, dispense_item, busy
   );

   modport master (
      output sup_valid, sup_item, sup_count, sup_cost,
      input  sup_ready,
      output usr_req, usr_item, usr_amount,
      input  usr_ack, usr_status, usr_change,
      input  dispense, dispense_item, busy
   );
endinterface

// File: rtl/vm2002_inventory_arb.sv
// Purpose : VM2002 per-item count/cost table, arbitrated between supplier
//           restock and user purchase; checks stock and payment, issues results.
// Latency : load = 2 cycles accept-to-next-arbitration; purchase = 3 cycles grant-to-ack.
// Backpressure: sup_ready only while IDLE and the supplier wins; usr_req held until usr_ack.
// Ports   : clk, hrst (async active-low), bus (slave modport of vm2002_inventory_arb_if).
module vm2002_inventory_arb #(
   parameter int IDX_W  = 2,
   parameter int CNT_W  = 4,
   parameter int COST_W = 8
) (
   input  logic                  clk,
   input  logic                  hrst,
   vm2002_inventory_arb_if.slave bus
);
   localparam int NUM_ITEMS = 2 ** IDX_W;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOAD   = 2'd1;
   localparam logic [1:0] ST_CHECK  = 2'd2;
   localparam logic [1:0] ST_RESULT = 2'd3;

   localparam logic [1:0] STAT_OK      = 2'b01;
   localparam logic [1:0] STAT_SOLDOUT = 2'b10;
   localparam logic [1:0] STAT_INSUFF  = 2'b11;

   localparam logic GRANT_SUP = 1'b0;
   localparam logic GRANT_USR = 1'b1;

   logic [1:0]        state;
   logic              last_grant;
   logic [CNT_W-1:0]  count_tbl [NUM_ITEMS];
   logic [COST_W-1:0] cost_tbl  [NUM_ITEMS];

   logic [IDX_W-1:0]  cap_item;
   logic [CNT_W-1:0]  cap_count;
   logic [COST_W-1:0] cap_cost;
   logic [15:0]       cap_amount;
   logic [1:0]        res_status;
   logic [15:0]       res_change;

   logic              ack_q;
   logic [1:0]        status_q;
   logic [15:0]       change_q;
   logic              disp_q;
   logic [IDX_W-1:0]  disp_item_q;

   logic              grant_sup;
   logic              grant_usr;
   logic [CNT_W-1:0]  cur_count;
   logic [COST_W-1:0] cur_cost;
   logic [15:0]       cost_ext;
   logic [CNT_W:0]    sat_sum;

   // Tie-break: the requester not granted last time wins.
   always_comb begin
      grant_sup = 1'b0;
      grant_usr = 1'b0;
      if (state == ST_IDLE) begin
         if (bus.sup_valid && (!bus.usr_req || last_grant == GRANT_USR))
            grant_sup = 1'b1;
         else if (bus.usr_req)
            grant_usr = 1'b1;
      end
   end

   // FSM sits in IDLE during reset, so gate with hrst to keep sup_ready low there.
   assign bus.sup_ready     = hrst & grant_sup;
   assign bus.busy          = (state != ST_IDLE);
   assign bus.usr_ack       = ack_q;
   assign bus.usr_status    = status_q;
   assign bus.usr_change    = change_q;
   assign bus.dispense      = disp_q;
   assign bus.dispense_item = disp_item_q;

   assign cur_count = count_tbl[cap_item];
   assign cur_cost  = cost_tbl[cap_item];
   assign cost_ext  = 16'(cur_cost);
   // One extra bit catches overflow so the count saturates instead of wrapping.
   assign sat_sum   = {1'b0, cur_count} + {1'b0, cap_count};

   always_ff @(posedge clk or negedge hrst) begin
      if (!hrst) begin
         state       <= ST_IDLE;
         last_grant  <= GRANT_USR;
         cap_item    <= '0;
         cap_count   <= '0;
         cap_cost    <= '0;
         cap_amount  <= '0;
         res_status  <= '0;
         res_change  <= '0;
         ack_q       <= 1'b0;
         status_q    <= '0;
         change_q    <= '0;
         disp_q      <= 1'b0;
         disp_item_q <= '0;
         for (int i = 0; i < NUM_ITEMS; i++) begin
            count_tbl[i] <= '0;
            cost_tbl[i]  <= '0;
         end
      end else begin
         ack_q  <= 1'b0;
         disp_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_sup) begin
                  cap_item   <= bus.sup_item;
                  cap_count  <= bus.sup_count;
                  cap_cost   <= bus.sup_cost;
                  last_grant <= GRANT_SUP;
                  state      <= ST_LOAD;
               end else if (grant_usr) begin
                  cap_item   <= bus.usr_item;
                  cap_amount <= bus.usr_amount;
                  last_grant <= GRANT_USR;
                  state      <= ST_CHECK;
               end
            end
            ST_LOAD: begin
               count_tbl[cap_item] <= sat_sum[CNT_W] ? '1 : sat_sum[CNT_W-1:0];
               cost_tbl[cap_item]  <= cap_cost;
               state               <= ST_IDLE;
            end
            ST_CHECK: begin
               if (cur_count == '0) begin
                  res_status <= STAT_SOLDOUT;
                  res_change <= cap_amount;
               end else if (cap_amount < cost_ext) begin
                  res_status <= STAT_INSUFF;
                  res_change <= cap_amount;
               end else begin
                  res_status          <= STAT_OK;
                  res_change          <= cap_amount - cost_ext;
                  count_tbl[cap_item] <= cur_count - CNT_W'(1);
               end
               state <= ST_RESULT;
            end
            ST_RESULT: begin
               ack_q    <= 1'b1;
               status_q <= res_status;
               change_q <= res_change;
               if (res_status == STAT_OK) begin
                  disp_q      <= 1'b1;
                  disp_item_q <= cap_item;
               end
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vm2002_inventory_arb.sv
// Purpose : self-checking bench for vm2002_inventory_arb; a table model predicts
//           each purchase result, pushed to a scoreboard and popped at usr_ack.
// Ports   : none (top-level bench); drives the interface master side directly.
module tb_vm2002_inventory_arb;
   localparam logic [1:0] S_NONE    = 2'b00;
   localparam logic [1:0] S_OK      = 2'b01;
   localparam logic [1:0] S_SOLDOUT = 2'b10;
   localparam logic [1:0] S_INSUFF  = 2'b11;

   typedef struct {
      logic [1:0]  status;
      logic [15:0] change;
      logic [1:0]  item;
   } exp_t;

   logic clk = 1'b0;
   logic hrst;
   always #5 clk = ~clk;

   vm2002_inventory_arb_if #(.IDX_W(2), .CNT_W(4), .COST_W(8)) bus ();

   vm2002_inventory_arb #(.IDX_W(2), .CNT_W(4), .COST_W(8)) dut (
      .clk  (clk),
      .hrst (hrst),
      .bus  (bus)
   );

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   int   m_cnt  [4];
   int   m_cost [4];
   logic [1:0] last_disp;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_cnt[i]  = 0;
         m_cost[i] = 0;
      end
      last_disp = 2'd0;
   endtask

   task automatic model_load(input int item, input int cnt, input int cost);
      m_cnt[item]  = (m_cnt[item] + cnt > 15) ? 15 : m_cnt[item] + cnt;
      m_cost[item] = cost;
   endtask

   task automatic model_buy(input int item, input int amount);
      exp_t e;
      e.item = 2'(item);
      if (m_cnt[item] == 0) begin
         e.status = S_SOLDOUT;
         e.change = 16'(amount);
      end else if (amount < m_cost[item]) begin
         e.status = S_INSUFF;
         e.change = 16'(amount);
      end else begin
         e.status = S_OK;
         e.change = 16'(amount - m_cost[item]);
         m_cnt[item] = m_cnt[item] - 1;
      end
      sb.push_back(e);
   endtask

   task automatic apply_reset();
      hrst           = 1'b0;
      bus.sup_valid  = 1'b1;   // supplier pending through reset must not see sup_ready
      bus.sup_item   = 2'd0;
      bus.sup_count  = 4'd0;
      bus.sup_cost   = 8'd0;
      bus.usr_req    = 1'b0;
      bus.usr_item   = 2'd0;
      bus.usr_amount = 16'd0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.sup_ready !== 1'b0 || bus.usr_ack !== 1'b0 || bus.usr_status !== S_NONE ||
          bus.usr_change !== 16'd0 || bus.dispense !== 1'b0 || bus.dispense_item !== 2'd0 ||
          bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got rdy=%b ack=%b st=%b chg=%0d disp=%b ditem=%0d busy=%b want all zero",
                  bus.sup_ready, bus.usr_ack, bus.usr_status, bus.usr_change, bus.dispense,
                  bus.dispense_item, bus.busy);
      end
      bus.sup_valid = 1'b0;
      @(negedge clk);
      hrst = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_busy got %b want 0", bus.busy);
      end
   endtask

   task automatic wait_idle();
      int w = 0;
      while (bus.busy !== 1'b0 && w < 50) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_timeout busy=%b want 0", bus.busy);
      end
   endtask

   // Waits for usr_ack (bounded), drops usr_req and compares against the scoreboard.
   task automatic wait_ack(input int exp_lat);
      int   n = 0;
      exp_t e;
      do begin
         @(negedge clk);
         n++;
      end while (bus.usr_ack !== 1'b1 && n < 20);
      bus.usr_req = 1'b0;
      checks++;
      if (bus.usr_ack !== 1'b1) begin
         errors++;
         $display("FAIL ack_timeout usr_ack=%b after %0d cycles want 1", bus.usr_ack, n);
      end
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty got 0 entries want 1");
         return;
      end
      e = sb.pop_front();
      checks++;
      if (n !== exp_lat) begin
         errors++;
         $display("FAIL ack_latency got %0d want %0d", n, exp_lat);
      end
      checks++;
      if (bus.usr_status !== e.status) begin
         errors++;
         $display("FAIL usr_status got %b want %b", bus.usr_status, e.status);
      end
      checks++;
      if (bus.usr_change !== e.change) begin
         errors++;
         $display("FAIL usr_change got %0d want %0d", bus.usr_change, e.change);
      end
      checks++;
      if (bus.dispense !== (e.status == S_OK)) begin
         errors++;
         $display("FAIL dispense got %b want %b", bus.dispense, (e.status == S_OK));
      end
      if (e.status == S_OK) last_disp = e.item;
      checks++;
      if (bus.dispense_item !== last_disp) begin
         errors++;
         $display("FAIL dispense_item got %0d want %0d", bus.dispense_item, last_disp);
      end
   endtask

   task automatic post_ack_check();
      logic [1:0]  st  = bus.usr_status;
      logic [15:0] chg = bus.usr_change;
      @(negedge clk);
      checks++;
      if (bus.usr_ack !== 1'b0 || bus.dispense !== 1'b0 || bus.usr_status !== st ||
          bus.usr_change !== chg) begin
         errors++;
         $display("FAIL pulse_hold got ack=%b disp=%b st=%b chg=%0d want ack=0 disp=0 st=%b chg=%0d",
                  bus.usr_ack, bus.dispense, bus.usr_status, bus.usr_change, st, chg);
      end
   endtask

   task automatic do_purchase(input int item, input int amount);
      wait_idle();
      bus.usr_req    = 1'b1;
      bus.usr_item   = 2'(item);
      bus.usr_amount = 16'(amount);
      model_buy(item, amount);
      wait_ack(3);
      post_ack_check();
   endtask

   task automatic do_load(input int item, input int cnt, input int cost);
      int w = 0;
      wait_idle();
      bus.sup_valid = 1'b1;
      bus.sup_item  = 2'(item);
      bus.sup_count = 4'(cnt);
      bus.sup_cost  = 8'(cost);
      #1;
      while (bus.sup_ready !== 1'b1 && w < 50) begin
         @(negedge clk);
         #1;
         w++;
      end
      checks++;
      if (bus.sup_ready !== 1'b1) begin
         errors++;
         $display("FAIL load_ready got %b want 1", bus.sup_ready);
      end
      model_load(item, cnt, cost);
      @(negedge clk);
      bus.sup_valid = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.sup_ready !== 1'b0) begin
         errors++;
         $display("FAIL load_state got busy=%b rdy=%b want busy=1 rdy=0", bus.busy, bus.sup_ready);
      end
   endtask

   task automatic test_reset();
      apply_reset();
   endtask

   task automatic test_soldout();
      do_purchase(1, 50);
   endtask

   task automatic test_load_purchase();
      do_load(2, 3, 25);
      do_purchase(2, 40);
   endtask

   task automatic test_insuff();
      do_purchase(2, 20);
      do_purchase(2, 25);
      do_load(1, 1, 0);       // free item
      do_purchase(1, 33);
      do_purchase(1, 33);     // count 0 outranks cost 0
   endtask

   task automatic test_saturation();
      do_load(0, 10, 7);
      do_load(0, 10, 7);
      for (int i = 0; i < 15; i++) do_purchase(0, 10);
      do_purchase(0, 10);
   endtask

   task automatic test_arbitration();
      apply_reset();
      // First tie after reset: supplier wins, user follows and sees the load.
      bus.sup_valid  = 1'b1;
      bus.sup_item   = 2'd1;
      bus.sup_count  = 4'd2;
      bus.sup_cost   = 8'd30;
      bus.usr_req    = 1'b1;
      bus.usr_item   = 2'd1;
      bus.usr_amount = 16'd30;
      #1;
      checks++;
      if (bus.sup_ready !== 1'b1) begin
         errors++;
         $display("FAIL tie1_sup_ready got %b want 1", bus.sup_ready);
      end
      model_load(1, 2, 30);
      model_buy(1, 30);
      @(negedge clk);
      bus.sup_valid = 1'b0;
      wait_ack(4);
      post_ack_check();
      // Supplier granted last: the user wins the next tie.
      do_load(2, 1, 9);
      wait_idle();
      bus.sup_valid  = 1'b1;
      bus.sup_item   = 2'd3;
      bus.sup_count  = 4'd4;
      bus.sup_cost   = 8'd1;
      bus.usr_req    = 1'b1;
      bus.usr_item   = 2'd2;
      bus.usr_amount = 16'd9;
      #1;
      checks++;
      if (bus.sup_ready !== 1'b0) begin
         errors++;
         $display("FAIL tie2_sup_ready got %b want 0", bus.sup_ready);
      end
      model_buy(2, 9);
      wait_ack(3);
      #1;
      checks++;
      if (bus.sup_ready !== 1'b1) begin
         errors++;
         $display("FAIL tie2_sup_after got %b want 1", bus.sup_ready);
      end
      model_load(3, 4, 1);
      @(negedge clk);
      bus.sup_valid = 1'b0;
      do_purchase(3, 5);
   endtask

   task automatic test_reset_mid();
      int acks = 0;
      do_load(3, 2, 5);
      do_purchase(3, 10);     // leaves dispense_item = 3
      wait_idle();
      bus.usr_req    = 1'b1;
      bus.usr_item   = 2'd3;
      bus.usr_amount = 16'd10;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_busy got %b want 1", bus.busy);
      end
      hrst = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.usr_ack !== 1'b0 || bus.usr_status !== S_NONE ||
          bus.usr_change !== 16'd0 || bus.dispense_item !== 2'd0 || bus.sup_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_outputs got busy=%b ack=%b st=%b chg=%0d ditem=%0d rdy=%b want all zero",
                  bus.busy, bus.usr_ack, bus.usr_status, bus.usr_change, bus.dispense_item, bus.sup_ready);
      end
      bus.usr_req = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.usr_ack !== 1'b0) acks++;
      end
      hrst = 1'b1;
      @(negedge clk);
      if (bus.usr_ack !== 1'b0) acks++;
      checks++;
      if (acks !== 0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_no_ack got acks=%0d busy=%b want 0 0", acks, bus.busy);
      end
      do_purchase(3, 10);     // table was cleared: SOLDOUT
   endtask

   initial begin
      test_reset();
      test_soldout();
      test_load_purchase();
      test_insuff();
      test_saturation();
      test_arbitration();
      test_reset_mid();
      checks++;
      if (sb.size() !== 0) begin
         errors++;
         $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vm2002_inventory_arb.md
# vm2002_inventory_arb

Inventory controller and arbiter for the VM2002 vending machine. It owns the per-item count/cost table and shares it between two requesters: the supplier restock port and the user purchase port. It serialises their accesses, checks each purchase against stock and paid amount, and issues dispense, change and status results to the output stage.

## Interface

Parameters:
- IDX_W, 2, item index width; table holds NUM_ITEMS = 2**IDX_W entries
- CNT_W, 4, per-item stock count width (saturating)
- COST_W, 8, per-item cost width

Ports:
- clk  input  1  single clock, all state on rising edge
- hrst  input  1  asynchronous, active-low reset
- sup_valid  input  1  supplier load request
- sup_item  input  IDX_W  item to restock
- sup_count  input  CNT_W  units added
- sup_cost  input  COST_W  new cost for item
- sup_ready  output  1  load accepted this cycle (transfer = sup_valid & sup_ready)
- usr_req  input  1  purchase request, held high until usr_ack
- usr_item  input  IDX_W  requested item
- usr_amount  input  16  amount paid, stable while usr_req high
- usr_ack  output  1  one-cycle pulse, purchase resolved
- usr_status  output  2  00 none, 01 OK, 10 SOLDOUT, 11 INSUFF; held until next ack
- usr_change  output  16  change/refund; held until next ack
- dispense  output  1  one-cycle pulse, coincident with usr_ack when status OK
- dispense_item  output  IDX_W  item dispensed; held until next dispense
- busy  output  1  high in any state other than IDLE

## Operation

- FSM states: IDLE, LOAD, CHECK, RESULT.
- IDLE: arbitrate between sup_valid and usr_req.
  - Only one pending: grant it.
  - Both pending: grant the requester not granted last (last_grant register; reset value = user, so the supplier wins the first tie).
- Supplier grant:
  - sup_ready is driven high combinationally in IDLE that cycle; the transfer completes on that edge.
  - Go to LOAD with the item, count and cost captured.
- LOAD (1 cycle):
  - count[item] = min(count[item] + sup_count, 2**CNT_W-1), saturating and never wrapping.
  - cost[item] = sup_cost, overwriting the old cost.
  - Then return to IDLE.
- User grant: capture usr_item and usr_amount, then go to CHECK.
- CHECK (1 cycle): read the entry and evaluate in priority order.
  - count == 0: SOLDOUT, change = amount.
  - amount < cost (cost zero-extended to 16 bits): INSUFF, change = amount.
  - Otherwise: OK, change = amount - cost, and count decrements by 1.
- RESULT (1 cycle):
  - Pulse usr_ack and update usr_status and usr_change.
  - On OK, pulse dispense and update dispense_item.
  - Return to IDLE.
- Edge cases:
  - amount == cost: OK with change 0.
  - cost == 0 with count > 0: OK, dispensed free, change = amount.
- The requester must drop usr_req the cycle after usr_ack. A usr_req still high in the cycle after RESULT is treated as a new purchase.
- Accesses are fully serialised, so a load and a purchase to the same item never overlap. A purchase granted after a load sees the updated entry.
- sup_ready is 0 outside IDLE and whenever the user wins arbitration. sup_valid may stay high while waiting.

## Timing

- Reset (hrst low, asynchronous):
  - FSM goes to IDLE and every table entry is cleared to count 0, cost 0.
  - last_grant = user.
  - Outputs: sup_ready 0, usr_ack 0, usr_status 00, usr_change 0, dispense 0, dispense_item 0, busy 0.
- Reset mid-transaction aborts with no ack and no table update. Deassertion is synchronised by the surrounding design.
- Load: accept at edge N (IDLE); table updated at edge N+1; next arbitration at edge N+2.
- Purchase: granted at edge N (IDLE); CHECK at N+1; usr_ack, dispense and outputs valid in the cycle after edge N+2. Latency is 3 cycles from grant to ack visibility.
- Outputs usr_ack, dispense, usr_status, usr_change and dispense_item are registered.
- Back-to-back alternating load/purchase throughput: a load every 2 cycles, a purchase every 3 cycles.

## Test plan

- Reset, then purchase item 1 with amount 50 → usr_ack, status SOLDOUT, change 50, no dispense.
- Load item 2 (count 3, cost 25), then purchase item 2 with amount 40 → status OK, change 15, dispense_item 2, count[2] = 2.
- Item 2 cost 25, purchase with amount 20 → status INSUFF, change 20. Then amount 25 → OK, change 0.
- Load item 0 with count 10 twice → count saturates at 15. Fifteen successful purchases follow, then the sixteenth returns SOLDOUT.
- sup_valid and usr_req both high from IDLE after reset → supplier granted first (sup_ready pulse), user granted next. Repeat the tie → grants alternate.
- Assert hrst low during CHECK → all outputs reset immediately, no usr_ack, the table clears, and the FSM is in IDLE after release.
